// File: rtl/ib_pkg.sv
// ib_pkg: shared widths, functional-unit classes and buffer entry layout
// for the instruction buffer.
package ib_pkg;
    localparam int WIDTH    = 4;
    localparam int XLEN     = 16;
    localparam int TAG_W    = 4;
    localparam int ROB_SIZE = 16;

    localparam logic [3:0] LSU_LO = 4'h8;
    localparam logic [3:0] BR_LO  = 4'hC;

    typedef enum logic [1:0] {FU_FXU, FU_LSU, FU_BR} fu_class_e;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [TAG_W-1:0] rt;
        logic             a_rdy;
        logic [XLEN-1:0]  a_val;
        logic [TAG_W-1:0] a_own;
        logic             b_rdy;
        logic [XLEN-1:0]  b_val;
        logic [TAG_W-1:0] b_own;
    } ib_entry_t;

    function automatic fu_class_e fu_class(input logic [3:0] op);
        return op >= BR_LO ? FU_BR : op >= LSU_LO ? FU_LSU : FU_FXU;
    endfunction
endpackage

// File: rtl/operand_resolve.sv
// operand_resolve: capture-time source operand resolution from the
// in-bundle dependency, the register file, or a finished ROB entry.
module operand_resolve
    import ib_pkg::*;
(
    input  logic                     used,
    input  logic                     local_dep,
    input  logic [TAG_W-1:0]         local_owner,
    input  logic                     busy,
    input  logic [XLEN-1:0]          reg_value,
    input  logic [TAG_W-1:0]         reg_owner,
    input  logic [ROB_SIZE-1:0]      rob_output_valid,
    input  logic [ROB_SIZE*XLEN-1:0] rob_output_values,
    output logic                     rdy,
    output logic [XLEN-1:0]          val,
    output logic [TAG_W-1:0]         own
);
    logic fwd;

    always_comb begin
        fwd = rob_output_valid[reg_owner];
        rdy = !used || (!local_dep && (!busy || fwd));
        val = !used || local_dep ? '0
            : !busy ? reg_value
            : fwd ? rob_output_values[int'(reg_owner)*XLEN +: XLEN] : '0;
        own = !used ? '0 : local_dep ? local_owner : (busy && !fwd) ? reg_owner : '0;
    end
endmodule

// File: rtl/instruction_buffer.sv
// instruction_buffer: four-wide in-order dispatch queue; captures decoded
// bundles, wakes operands on ROB results and issues oldest entries in order.
module instruction_buffer
    import ib_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instructions_valid,
    input  logic [WIDTH*4-1:0]       opcode_in,
    input  logic [WIDTH-1:0]         op_a_local_dep,
    input  logic [WIDTH-1:0]         op_b_local_dep,
    input  logic [WIDTH*TAG_W-1:0]   op_a_owner_in,
    input  logic [WIDTH*TAG_W-1:0]   op_b_owner_in,
    input  logic [WIDTH*TAG_W-1:0]   rt_in,
    input  logic [WIDTH-1:0]         uses_rb,
    input  logic [WIDTH*XLEN-1:0]    ra_value,
    input  logic [WIDTH*XLEN-1:0]    rb_value,
    input  logic [WIDTH-1:0]         ra_busy,
    input  logic [WIDTH-1:0]         rb_busy,
    input  logic [WIDTH*TAG_W-1:0]   ra_owner,
    input  logic [WIDTH*TAG_W-1:0]   rb_owner,
    input  logic [ROB_SIZE-1:0]      rob_output_valid,
    input  logic [ROB_SIZE*XLEN-1:0] rob_output_values,
    input  logic                     fxu_0_full,
    input  logic                     fxu_1_full,
    input  logic                     lsu_full,
    input  logic                     branch_full,
    output logic [$clog2(DEPTH+1)-1:0] num_slots,
    output logic [WIDTH-1:0]         out_valid,
    output logic [WIDTH-1:0]         out_a_valid,
    output logic [WIDTH-1:0]         out_b_valid,
    output logic [WIDTH*XLEN-1:0]    out_a_value,
    output logic [WIDTH*XLEN-1:0]    out_b_value,
    output logic [WIDTH*TAG_W-1:0]   out_a_owner,
    output logic [WIDTH*TAG_W-1:0]   out_b_owner,
    output logic [WIDTH*TAG_W-1:0]   out_rt,
    output logic [WIDTH*4-1:0]       opcode
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, num_slots_q, num_slots_d, n_iss;
    logic [WIDTH-1:0] out_valid_q, out_valid_d;
    ib_entry_t        ent_q [DEPTH];
    ib_entry_t        ent_d [DEPTH];
    ib_entry_t        woke [DEPTH];
    ib_entry_t        out_q [WIDTH];
    ib_entry_t        out_d [WIDTH];
    ib_entry_t        cap [WIDTH];
    ib_entry_t        cand;
    logic             enq, go, avail, fxu_ok;
    logic [WIDTH-1:0] a_rdy, b_rdy;
    logic [XLEN-1:0]  a_val [WIDTH];
    logic [XLEN-1:0]  b_val [WIDTH];
    logic [TAG_W-1:0] a_own [WIDTH];
    logic [TAG_W-1:0] b_own [WIDTH];

    function automatic ib_entry_t wake(input ib_entry_t e, input logic [ROB_SIZE-1:0] v,
                                       input logic [ROB_SIZE*XLEN-1:0] vals);
        ib_entry_t r = e;
        if (!e.a_rdy && v[e.a_own]) begin
            r.a_rdy = 1'b1;
            r.a_val = vals[int'(e.a_own)*XLEN +: XLEN];
        end
        if (!e.b_rdy && v[e.b_own]) begin
            r.b_rdy = 1'b1;
            r.b_val = vals[int'(e.b_own)*XLEN +: XLEN];
        end
        return r;
    endfunction

    for (genvar s = 0; s < WIDTH; s++) begin : g_res
        operand_resolve u_a (
            .used(1'b1), .local_dep(op_a_local_dep[s]),
            .local_owner(op_a_owner_in[s*TAG_W +: TAG_W]), .busy(ra_busy[s]),
            .reg_value(ra_value[s*XLEN +: XLEN]), .reg_owner(ra_owner[s*TAG_W +: TAG_W]),
            .rob_output_valid(rob_output_valid), .rob_output_values(rob_output_values),
            .rdy(a_rdy[s]), .val(a_val[s]), .own(a_own[s])
        );
        operand_resolve u_b (
            .used(uses_rb[s]), .local_dep(op_b_local_dep[s]),
            .local_owner(op_b_owner_in[s*TAG_W +: TAG_W]), .busy(rb_busy[s]),
            .reg_value(rb_value[s*XLEN +: XLEN]), .reg_owner(rb_owner[s*TAG_W +: TAG_W]),
            .rob_output_valid(rob_output_valid), .rob_output_values(rob_output_values),
            .rdy(b_rdy[s]), .val(b_val[s]), .own(b_own[s])
        );
    end

    always_comb begin
        fxu_ok = !fxu_0_full || !fxu_1_full;
        enq = instructions_valid && (CNT_W'(DEPTH) - count_q) >= CNT_W'(WIDTH);
        for (int i = 0; i < DEPTH; i++) begin
            woke[i]  = wake(ent_q[i], rob_output_valid, rob_output_values);
            ent_d[i] = woke[i];
        end
        // Issue stops at the first entry that is missing or whose unit is blocked.
        go = 1'b1;
        n_iss = '0;
        out_valid_d = '0;
        cand = '0;
        avail = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            cand = woke[head_q + PTR_W'(k)];
            avail = fu_class(cand.opcode) == FU_FXU ? fxu_ok
                  : fu_class(cand.opcode) == FU_LSU ? !lsu_full : !branch_full;
            go = go && CNT_W'(k) < count_q && avail;
            out_valid_d[k] = go;
            out_d[k] = go ? cand : '0;
            n_iss = n_iss + CNT_W'(go);
        end
        for (int s = 0; s < WIDTH; s++) begin
            cap[s] = '{opcode: opcode_in[s*4 +: 4], rt: rt_in[s*TAG_W +: TAG_W],
                       a_rdy: a_rdy[s], a_val: a_val[s], a_own: a_own[s],
                       b_rdy: b_rdy[s], b_val: b_val[s], b_own: b_own[s]};
            if (enq)
                ent_d[tail_q + PTR_W'(s)] = cap[s];
        end
        head_d = head_q + PTR_W'(n_iss);
        tail_d = tail_q + (enq ? PTR_W'(WIDTH) : '0);
        count_d = count_q + (enq ? CNT_W'(WIDTH) : '0) - n_iss;
        num_slots_d = CNT_W'(DEPTH) - count_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            num_slots_q <= CNT_W'(DEPTH);
            out_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            for (int k = 0; k < WIDTH; k++) out_q[k] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            num_slots_q <= num_slots_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            for (int k = 0; k < WIDTH; k++) out_q[k] <= out_d[k];
        end
    end

    always_comb begin
        num_slots = num_slots_q;
        out_valid = out_valid_q;
        for (int s = 0; s < WIDTH; s++) begin
            out_a_valid[s] = out_q[s].a_rdy;
            out_b_valid[s] = out_q[s].b_rdy;
            out_a_value[s*XLEN +: XLEN] = out_q[s].a_val;
            out_b_value[s*XLEN +: XLEN] = out_q[s].b_val;
            out_a_owner[s*TAG_W +: TAG_W] = out_q[s].a_own;
            out_b_owner[s*TAG_W +: TAG_W] = out_q[s].b_own;
            out_rt[s*TAG_W +: TAG_W] = out_q[s].rt;
            opcode[s*4 +: 4] = out_q[s].opcode;
        end
    end
endmodule

// File: tb/tb_instruction_buffer.sv
// tb_instruction_buffer: directed vector table plus hand-written sequences
// for forwarding, wakeup, fill/drop and asynchronous reset.
module tb_instruction_buffer;
    logic         clk, rst, instructions_valid;
    logic [15:0]  opcode_in;
    logic [3:0]   op_a_local_dep, op_b_local_dep, uses_rb, ra_busy, rb_busy;
    logic [15:0]  op_a_owner_in, op_b_owner_in, rt_in, ra_owner, rb_owner;
    logic [63:0]  ra_value, rb_value;
    logic [15:0]  rob_output_valid;
    logic [255:0] rob_output_values;
    logic         fxu_0_full, fxu_1_full, lsu_full, branch_full;
    logic [3:0]   num_slots, out_valid, out_a_valid, out_b_valid;
    logic [63:0]  out_a_value, out_b_value;
    logic [15:0]  out_a_owner, out_b_owner, out_rt, opcode;

    int tests = 0;
    int failed = 0;

    instruction_buffer dut (
        .clk(clk), .rst(rst), .instructions_valid(instructions_valid),
        .opcode_in(opcode_in), .op_a_local_dep(op_a_local_dep),
        .op_b_local_dep(op_b_local_dep), .op_a_owner_in(op_a_owner_in),
        .op_b_owner_in(op_b_owner_in), .rt_in(rt_in), .uses_rb(uses_rb),
        .ra_value(ra_value), .rb_value(rb_value), .ra_busy(ra_busy), .rb_busy(rb_busy),
        .ra_owner(ra_owner), .rb_owner(rb_owner), .rob_output_valid(rob_output_valid),
        .rob_output_values(rob_output_values), .fxu_0_full(fxu_0_full),
        .fxu_1_full(fxu_1_full), .lsu_full(lsu_full), .branch_full(branch_full),
        .num_slots(num_slots), .out_valid(out_valid), .out_a_valid(out_a_valid),
        .out_b_valid(out_b_valid), .out_a_value(out_a_value), .out_b_value(out_b_value),
        .out_a_owner(out_a_owner), .out_b_owner(out_b_owner), .out_rt(out_rt),
        .opcode(opcode)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] opc;
        logic [63:0] ra;
        logic [3:0]  full;
        logic [3:0]  exp_valid;
        logic [63:0] exp_a;
        logic [3:0]  exp_slots;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] vmask(input logic [3:0] v);
        logic [63:0] m;
        for (int s = 0; s < 4; s++) m[s*16 +: 16] = {16{v[s]}};
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instructions_valid = 0; opcode_in = '0;
        op_a_local_dep = '0; op_b_local_dep = '0; op_a_owner_in = '0; op_b_owner_in = '0;
        rt_in = '0; uses_rb = '0; ra_value = '0; rb_value = '0; ra_busy = '0; rb_busy = '0;
        ra_owner = '0; rb_owner = '0; rob_output_valid = '0; rob_output_values = '0;
        {fxu_0_full, fxu_1_full, lsu_full, branch_full} = '0;
    endtask

    task automatic reset_dut();
        rst = 1;
        #2;
        rst = 0;
    endtask

    initial begin
        vecs[0] = '{16'h0000, 64'h0008_0007_0006_0005, 4'b0000, 4'b1111, 64'h0008_0007_0006_0005, 4'd8};
        vecs[1] = '{16'h7D93, 64'h0004_0003_0002_0001, 4'b0000, 4'b1111, 64'h0004_0003_0002_0001, 4'd8};
        vecs[2] = '{16'hC080, 64'h0014_0013_0012_0011, 4'b0010, 4'b0001, 64'h0000_0000_0000_0011, 4'd5};
        vecs[3] = '{16'h000C, 64'h0004_0003_0002_0001, 4'b0001, 4'b0000, 64'h0, 4'd4};
        vecs[4] = '{16'h8000, 64'h0024_0023_0022_0021, 4'b0010, 4'b0111, 64'h0000_0023_0022_0021, 4'd7};
        vecs[5] = '{16'h0000, 64'h0034_0033_0032_0031, 4'b1000, 4'b1111, 64'h0034_0033_0032_0031, 4'd8};
        vecs[6] = '{16'h00C8, 64'h0044_0043_0042_0041, 4'b1100, 4'b0011, 64'h0000_0000_0042_0041, 4'd6};

        clear_inputs();
        rst = 1;
        repeat (2) step();
        check("reset num_slots", 64'(num_slots), 64'd8);
        check("reset out_valid", 64'(out_valid), 64'h0);
        rst = 0;
        repeat (2) step();
        check("idle num_slots", 64'(num_slots), 64'd8);
        check("idle out_valid", 64'(out_valid), 64'h0);

        for (int i = 0; i < 7; i++) begin
            reset_dut();
            clear_inputs();
            opcode_in = vecs[i].opc;
            ra_value = vecs[i].ra;
            {fxu_0_full, fxu_1_full, lsu_full, branch_full} = vecs[i].full;
            instructions_valid = 1;
            step();
            instructions_valid = 0;
            step();
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d a_value", i), out_a_value & vmask(vecs[i].exp_valid), vecs[i].exp_a);
            check($sformatf("vec%0d num_slots", i), 64'(num_slots), 64'(vecs[i].exp_slots));
        end

        // Local dependency, ROB forwarding at capture, and B operand paths.
        reset_dut();
        clear_inputs();
        ra_value = 64'h0004_0003_0002_0001;
        op_a_local_dep = 4'b0010;
        op_a_owner_in = 16'h0030;
        ra_busy = 4'b0100;
        ra_owner = 16'h0900;
        rob_output_valid[9] = 1;
        rob_output_values[9*16 +: 16] = 16'h00AA;
        uses_rb = 4'b0001;
        rb_busy = 4'b0001;
        rb_owner = 16'h0007;
        instructions_valid = 1;
        step();
        instructions_valid = 0;
        rob_output_valid = '0;
        step();
        check("fwd out_valid", 64'(out_valid), 64'hF);
        check("fwd a_valid", 64'(out_a_valid), 64'b1101);
        check("fwd a_owner slot1", 64'(out_a_owner[7:4]), 64'd3);
        check("fwd a_value slot2", 64'(out_a_value[47:32]), 64'h00AA);
        check("fwd b_valid", 64'(out_b_valid), 64'b1110);
        check("fwd b_owner slot0", 64'(out_b_owner[3:0]), 64'd7);

        // LSU backpressure then release.
        reset_dut();
        clear_inputs();
        opcode_in = 16'hC080;
        ra_value = 64'h0004_0003_0002_0001;
        lsu_full = 1;
        instructions_valid = 1;
        step();
        instructions_valid = 0;
        step();
        check("lsu hold out_valid", 64'(out_valid), 64'b0001);
        check("lsu hold num_slots", 64'(num_slots), 64'd5);
        lsu_full = 0;
        step();
        check("lsu rel out_valid", 64'(out_valid), 64'b0111);
        check("lsu rel opcode", 64'(opcode[11:0]), 64'hC08);
        check("lsu rel a_value", 64'(out_a_value[47:0]), 64'h0004_0003_0002);
        check("lsu rel num_slots", 64'(num_slots), 64'd8);

        // Wakeup while held, and wakeup in the issuing cycle.
        reset_dut();
        clear_inputs();
        fxu_0_full = 1;
        fxu_1_full = 1;
        ra_busy = 4'b0011;
        ra_owner = 16'h0054;
        instructions_valid = 1;
        step();
        instructions_valid = 0;
        ra_busy = '0;
        rob_output_valid[4] = 1;
        rob_output_values[4*16 +: 16] = 16'h1234;
        step();
        check("wake held out_valid", 64'(out_valid), 64'h0);
        rob_output_valid = '0;
        rob_output_valid[5] = 1;
        rob_output_values[5*16 +: 16] = 16'h5678;
        fxu_0_full = 0;
        step();
        check("wake out_valid", 64'(out_valid), 64'hF);
        check("wake a_valid", 64'(out_a_valid), 64'hF);
        check("wake a_value", 64'(out_a_value[31:0]), 64'h5678_1234);

        // Fill, drop, drain, then asynchronous reset mid-cycle.
        reset_dut();
        clear_inputs();
        {fxu_0_full, fxu_1_full, lsu_full, branch_full} = 4'hF;
        instructions_valid = 1;
        opcode_in = 16'h1111;
        step();
        opcode_in = 16'h2222;
        step();
        check("fill num_slots", 64'(num_slots), 64'd0);
        opcode_in = 16'h3333;
        step();
        check("drop num_slots", 64'(num_slots), 64'd0);
        check("drop out_valid", 64'(out_valid), 64'h0);
        instructions_valid = 0;
        {fxu_0_full, fxu_1_full, lsu_full, branch_full} = 4'h0;
        step();
        check("drain1 opcode", 64'(opcode), 64'h1111);
        check("drain1 num_slots", 64'(num_slots), 64'd4);
        step();
        check("drain2 opcode", 64'(opcode), 64'h2222);
        check("drain2 num_slots", 64'(num_slots), 64'd8);
        step();
        check("drain3 out_valid", 64'(out_valid), 64'h0);
        opcode_in = 16'h0000;
        instructions_valid = 1;
        step();
        instructions_valid = 0;
        step();
        check("pre-rst out_valid", 64'(out_valid), 64'hF);
        #2;
        rst = 1;
        #1;
        check("async rst num_slots", 64'(num_slots), 64'd8);
        check("async rst out_valid", 64'(out_valid), 64'h0);
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
